// File: rtl/fetch.sv
// Instruction fetch unit: one current word plus an optional sequential prefetch entry,
// fed from a request/grant/response memory port with at most one request outstanding.
module fetch #(
  parameter bit PREFETCH_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        fault_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] cur_data_q, cur_data_d;
  logic        cur_valid_q, cur_valid_d;
  logic [31:0] pf_addr_q, pf_addr_d;
  logic [31:0] pf_data_q, pf_data_d;
  logic        pf_valid_q, pf_valid_d;
  logic        fault_q, fault_d;
  // Destination of the outstanding request: 1 = prefetch entry, 0 = current entry.
  logic        tgt_pf_q, tgt_pf_d;
  logic [31:0] req_addr_q, req_addr_d;

  logic cur_hit;
  logic pf_hit;

  assign cur_hit = cur_valid_q && (cur_addr_q == pc_i);
  assign pf_hit  = PREFETCH_EN && pf_valid_q && (pf_addr_q == pc_i);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    cur_data_d  = cur_data_q;
    cur_valid_d = cur_valid_q;
    pf_addr_d   = pf_addr_q;
    pf_data_d   = pf_data_q;
    pf_valid_d  = pf_valid_q;
    fault_d     = fault_q;
    tgt_pf_d    = tgt_pf_q;
    req_addr_d  = req_addr_q;

    unique case (state_q)
      StIdle: begin
        // A set fault freezes the unit until reset.
        if (!fault_q) begin
          if (!cur_hit) begin
            if (pf_hit) begin
              cur_addr_d  = pf_addr_q;
              cur_data_d  = pf_data_q;
              cur_valid_d = 1'b1;
              pf_valid_d  = 1'b0;
            end else if (pc_i[1:0] != 2'b00) begin
              fault_d = 1'b1;
            end else begin
              cur_valid_d = 1'b0;
              pf_valid_d  = 1'b0;
              tgt_pf_d    = 1'b0;
              req_addr_d  = pc_i;
              state_d     = StReq;
            end
          end else if (PREFETCH_EN && !pf_valid_q) begin
            tgt_pf_d   = 1'b1;
            req_addr_d = cur_addr_q + 32'd4;
            state_d    = StReq;
          end
        end
      end

      StReq: begin
        if (mem_gnt_i) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (mem_rvalid_i) begin
          state_d = StIdle;
          if (!mem_err_i) begin
            // Stale data is still written; the pc compare hides it.
            if (!fault_q) begin
              if (tgt_pf_q) begin
                pf_addr_d  = req_addr_q;
                pf_data_d  = mem_rdata_i;
                pf_valid_d = 1'b1;
              end else begin
                cur_addr_d  = req_addr_q;
                cur_data_d  = mem_rdata_i;
                cur_valid_d = 1'b1;
              end
            end
          end else if (!tgt_pf_q) begin
            fault_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      cur_data_q  <= '0;
      cur_valid_q <= 1'b0;
      pf_addr_q   <= '0;
      pf_data_q   <= '0;
      pf_valid_q  <= 1'b0;
      fault_q     <= 1'b0;
      tgt_pf_q    <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      cur_data_q  <= cur_data_d;
      cur_valid_q <= cur_valid_d;
      pf_addr_q   <= pf_addr_d;
      pf_data_q   <= pf_data_d;
      pf_valid_q  <= pf_valid_d;
      fault_q     <= fault_d;
      tgt_pf_q    <= tgt_pf_d;
      req_addr_q  <= req_addr_d;
    end
  end

  assign inst_valid_o = cur_hit && !fault_q;
  assign inst_o       = cur_data_q;
  assign mem_req_o    = (state_q == StReq);
  assign mem_addr_o   = req_addr_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: a behavioural memory with programmable grant/latency/error behaviour,
// directed scenario tasks and a randomized run checked against the memory contents.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err = 1'b0;
  logic        fault;

  int checks = 0;
  int failures = 0;

  // Memory model knobs
  bit          hold_gnt = 1'b0;
  bit          rand_mode = 1'b0;
  bit          spurious = 1'b0;
  int          fixed_lat = 1;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] gnt_log[$];

  always #5 clk = ~clk;

  fetch #(.PREFETCH_EN(1'b1)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .pc_i        (pc),
    .inst_valid_o(inst_valid),
    .inst_o      (inst),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_gnt_i   (mem_gnt),
    .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i (mem_rdata),
    .mem_err_i   (mem_err),
    .fault_o     (fault)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0;
    if (a == 32'h4) return 32'h0010_2003;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic int log_count(input logic [31:0] a);
    int n = 0;
    foreach (gnt_log[i]) if (gnt_log[i] == a) n++;
    return n;
  endfunction

  // Memory: a grant driven in one cycle is taken at the next edge; the response follows
  // the configured number of cycles after the grant cycle.
  initial begin
    bit          pend = 1'b0;
    int          delay = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] gaddr = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
      mem_rdata  = $urandom;
      if (reset) begin
        pend    = 1'b0;
        mem_gnt = 1'b0;
      end else begin
        if (mem_gnt) begin
          pend      = 1'b1;
          pend_addr = gaddr;
          delay     = rand_mode ? int'($urandom_range(0, 2)) : fixed_lat - 1;
          gnt_log.push_back(gaddr);
        end
        if (pend) begin
          if (delay == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memfn(pend_addr);
            mem_err    = err_en && (pend_addr == err_addr);
            pend       = 1'b0;
          end else begin
            delay--;
          end
        end else if (spurious && $urandom_range(0, 3) == 0) begin
          mem_rvalid = 1'b1;
          mem_err    = 1'($urandom_range(0, 1));
        end
        mem_gnt = 1'b0;
        if (mem_req === 1'b1 && !pend && !hold_gnt &&
            (!rand_mode || $urandom_range(0, 2) != 0)) begin
          mem_gnt = 1'b1;
          gaddr   = mem_addr;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first cycle after reset release (inputs driven at posedge+1).
  task automatic do_reset(input logic [31:0] p);
    step();
    reset = 1'b1;
    pc    = p;
    step();
    step();
    gnt_log.delete();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step();
    reset = 1'b1;
    pc    = 32'h100;
    step();
    step();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
    end
    checks++;
    if (inst !== 32'h0) begin
      failures++; $display("FAIL reset_inst: got %h want 00000000", inst);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL reset_mem_req: got %b want 0", mem_req);
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      failures++; $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr);
    end
    checks++;
    if (fault !== 1'b0) begin
      failures++; $display("FAIL reset_fault: got %b want 0", fault);
    end
  endtask

  // Demand miss latency: valid exactly three cycles after reset release.
  task automatic test_demand_latency();
    fixed_lat = 1;
    do_reset(32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== (k == 3)) begin
        failures++; $display("FAIL demand_valid_c%0d: got %b want %b", k, inst_valid, k == 3);
      end
      if (k == 1) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
          failures++; $display("FAIL demand_req: got req=%b addr=%h want req=1 addr=0",
                               mem_req, mem_addr);
        end
      end
      if (k == 3) begin
        checks++;
        if (inst !== 32'h0) begin
          failures++; $display("FAIL demand_data: got %h want 00000000", inst);
        end
      end
      step();
    end
  endtask

  // Continues from test_demand_latency: prefetch of address 4 while pc stays at 0.
  task automatic test_prefetch();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
      failures++; $display("FAIL prefetch_issue: got req=%b addr=%h want req=1 addr=4",
                           mem_req, mem_addr);
    end
    repeat (3) step();
    pc = 32'h4;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++; $display("FAIL prefetch_drop_same_cycle: got %b want 0", inst_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0010_2003) begin
      failures++; $display("FAIL prefetch_hit: got valid=%b inst=%h want valid=1 inst=00102003",
                           inst_valid, inst);
    end
    repeat (3) step();
    checks++;
    if (log_count(32'h4) !== 1) begin
      failures++; $display("FAIL prefetch_no_demand: got %0d grants to 4 want 1",
                           log_count(32'h4));
    end
  endtask

  // pc moves while the 0x10 demand is outstanding.
  task automatic test_stale();
    bit seen = 1'b0;
    bit bad = 1'b0;
    fixed_lat = 3;
    do_reset(32'h10);
    step();
    step();
    pc = 32'h40;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid) bad = 1'b1;
      if (mem_req && mem_addr == 32'h40) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++; $display("FAIL stale_new_req: got seen=%b want 1", seen);
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++; $display("FAIL stale_suppressed: got valid_seen=%b want 0", bad);
    end
    checks++;
    if (log_count(32'h10) !== 1) begin
      failures++; $display("FAIL stale_old_req: got %0d grants to 10 want 1", log_count(32'h10));
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1 || inst !== memfn(32'h40)) begin
      failures++; $display("FAIL stale_final: got valid=%b inst=%h want valid=1 inst=%h",
                           seen, inst, memfn(32'h40));
    end
    fixed_lat = 1;
  endtask

  task automatic test_misaligned();
    bit bad = 1'b0;
    do_reset(32'h6);
    @(negedge clk);
    checks++;
    if (fault !== 1'b0) begin
      failures++; $display("FAIL misalign_fault_early: got %b want 0", fault);
    end
    step();
    @(negedge clk);
    checks++;
    if (fault !== 1'b1) begin
      failures++; $display("FAIL misalign_fault: got %b want 1", fault);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 4) pc = 32'h0;
      @(negedge clk);
      if (mem_req || inst_valid || !fault) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++; $display("FAIL misalign_sticky: got bad=%b want 0", bad);
    end
  endtask

  task automatic test_mem_err();
    bit seen = 1'b0;
    bit bad = 1'b0;
    int c0;
    err_en   = 1'b1;
    err_addr = 32'h20;
    do_reset(32'h20);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (fault) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++; $display("FAIL demand_err_fault: got %b want 1", seen);
    end
    step();
    pc = 32'h24;
    c0 = gnt_log.size();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_req || inst_valid || !fault) bad = 1'b1;
      step();
    end
    checks++;
    if (bad !== 1'b0 || gnt_log.size() != c0) begin
      failures++; $display("FAIL demand_err_sticky: got bad=%b grants=%0d want bad=0 grants=%0d",
                           bad, gnt_log.size(), c0);
    end

    err_addr = 32'h34;
    do_reset(32'h30);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1 || inst !== memfn(32'h30)) begin
      failures++; $display("FAIL pferr_first: got valid=%b inst=%h want valid=1 inst=%h",
                           seen, inst, memfn(32'h30));
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_rvalid && mem_err) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++; $display("FAIL pferr_response: got %b want 1", seen);
    end
    step();
    pc     = 32'h34;
    err_en = 1'b0;
    c0     = log_count(32'h34);
    @(negedge clk);
    checks++;
    if (fault !== 1'b0) begin
      failures++; $display("FAIL pferr_no_fault: got %b want 0", fault);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1 || inst !== memfn(32'h34) || log_count(32'h34) != c0 + 1) begin
      failures++; $display("FAIL pferr_refetch: got valid=%b inst=%h grants=%0d want 1 %h %0d",
                           seen, inst, log_count(32'h34), memfn(32'h34), c0 + 1);
    end
  endtask

  task automatic test_gnt_stall();
    logic [31:0] a0;
    hold_gnt = 1'b1;
    do_reset(32'h80);
    step();
    @(negedge clk);
    a0 = mem_addr;
    checks++;
    if (mem_req !== 1'b1 || a0 !== 32'h80) begin
      failures++; $display("FAIL stall_req: got req=%b addr=%h want req=1 addr=80", mem_req, a0);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      pc = 32'($urandom_range(0, 63)) << 2;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
        failures++; $display("FAIL stall_hold_c%0d: got req=%b addr=%h want req=1 addr=80",
                             i, mem_req, mem_addr);
      end
    end
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      failures++; $display("FAIL reset_in_req: got req=%b addr=%h want req=0 addr=0",
                           mem_req, mem_addr);
    end
    hold_gnt = 1'b0;
  endtask

  // Top-of-memory word: the sequential prefetch address wraps to 0.
  task automatic test_wrap();
    bit seen = 1'b0;
    do_reset(32'hFFFF_FFFC);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1 || inst !== memfn(32'hFFFF_FFFC)) begin
      failures++; $display("FAIL wrap_fetch: got valid=%b inst=%h want valid=1 inst=%h",
                           seen, inst, memfn(32'hFFFF_FFFC));
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1 || mem_addr !== 32'h0) begin
      failures++; $display("FAIL wrap_prefetch: got req=%b addr=%h want req=1 addr=0",
                           seen, mem_addr);
    end
  endtask

  task automatic test_random();
    int stall = 0;
    int max_stall = 0;
    int hits = 0;
    bit vsamp;
    int unsigned r;
    rand_mode = 1'b1;
    spurious  = 1'b1;
    do_reset(32'h0);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (inst_valid) begin
        hits++;
        checks++;
        if (inst !== memfn(pc)) begin
          failures++; $display("FAIL rand_data pc=%h: got %h want %h", pc, inst, memfn(pc));
        end
      end
      if (mem_req) begin
        checks++;
        if (mem_addr[1:0] !== 2'b00) begin
          failures++; $display("FAIL rand_align: got addr=%h want word aligned", mem_addr);
        end
      end
      stall = inst_valid ? 0 : stall + 1;
      if (stall > max_stall) max_stall = stall;
      vsamp = inst_valid;
      step();
      r = $urandom_range(0, 15);
      if (vsamp && r < 10) begin
        pc = (pc + 32'd4) & 32'h0000_00FC;
        stall = 0;
      end else if (r == 15) begin
        pc = 32'($urandom_range(0, 63)) << 2;
        stall = 0;
      end
    end
    checks++;
    if (max_stall > 40) begin
      failures++; $display("FAIL rand_liveness: got max stall %0d want <= 40", max_stall);
    end
    checks++;
    if (hits < 100) begin
      failures++; $display("FAIL rand_progress: got %0d valid cycles want >= 100", hits);
    end
    checks++;
    if (fault !== 1'b0) begin
      failures++; $display("FAIL rand_no_fault: got %b want 0", fault);
    end
    rand_mode = 1'b0;
    spurious  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit reached want completion");
    $fatal(1, "tb_fetch timeout");
  end

  initial begin
    test_reset();
    test_demand_latency();
    test_prefetch();
    test_stale();
    test_misaligned();
    test_mem_err();
    test_gnt_stall();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
